// File: rtl/relu_pkg.sv
// Shared float32 view and sign classification for the ReLU backward datapath.
package relu_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } float32_t;

    localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;
    localparam logic [31:0] FP_POS_ZERO = 32'h0;

    // Only strictly positive, non-NaN activations let the gradient through.
    function automatic logic is_positive(float32_t f);
        return !f.sign && ({f.exp, f.man} != 31'd0) &&
               !((f.exp == FP_EXP_MAX) && (f.man != 23'd0));
    endfunction

endpackage

// File: rtl/relu_bwd_lane.sv
// Combinational per-lane ReLU / leaky-ReLU gradient gate.
module relu_bwd_lane
    import relu_pkg::*;
#(
    parameter int unsigned LEAKY       = 0,
    parameter int unsigned SLOPE_SHIFT = 3
) (
    input  logic [31:0] i_fwd,
    input  logic [31:0] i_grad,
    output logic [31:0] o_grad,
    output logic        o_neg
);

    localparam logic [7:0] SHIFT_E = 8'(SLOPE_SHIFT);

    float32_t w_fwd;
    float32_t w_grad;
    float32_t w_scaled;

    always_comb begin
        w_fwd    = float32_t'(i_fwd);
        w_grad   = float32_t'(i_grad);
        o_neg    = !is_positive(w_fwd);
        w_scaled = w_grad;
        // Scaling by 2^-SLOPE_SHIFT is an exponent decrement; underflow flushes to signed zero.
        if (w_grad.exp == FP_EXP_MAX) begin
            w_scaled = w_grad;
        end else if (w_grad.exp <= SHIFT_E) begin
            w_scaled = {w_grad.sign, 31'd0};
        end else begin
            w_scaled.exp = w_grad.exp - SHIFT_E;
        end

        if (!o_neg) begin
            o_grad = i_grad;
        end else if (LEAKY != 0) begin
            o_grad = w_scaled;
        end else begin
            o_grad = FP_POS_ZERO;
        end
    end

endmodule

// File: rtl/relu_backward_lanes.sv
// Two-stage valid/ready ReLU backward unit with a saturating gated-lane counter.
module relu_backward_lanes
    import relu_pkg::*;
#(
    parameter int unsigned LANES       = 4,
    parameter int unsigned LEAKY       = 0,
    parameter int unsigned SLOPE_SHIFT = 3,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*LANES-1:0]   fwd_data,
    input  logic [32*LANES-1:0]   grad_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*LANES-1:0]   grad_out,
    input  logic                  clr_count,
    output logic [CNT_W-1:0]      gated_count
);

    localparam int unsigned W     = 32 * LANES;
    localparam int unsigned PC_W  = $clog2(LANES + 1);
    localparam int unsigned SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_s1_valid;
    logic [W-1:0]     r_s1_fwd;
    logic [W-1:0]     r_s1_grad;
    logic             r_s2_valid;
    logic [W-1:0]     r_s2_grad;
    logic [PC_W-1:0]  r_s2_pop;
    logic [CNT_W-1:0] r_count;

    logic [W-1:0]     w_lane_grad;
    logic [LANES-1:0] w_neg;
    logic [PC_W-1:0]  w_pop;
    logic             w_s1_ready;
    logic             w_s2_ready;
    logic             w_out_hs;
    logic [SUM_W-1:0] w_sum;
    logic [CNT_W-1:0] w_count_d;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        relu_bwd_lane #(
            .LEAKY       (LEAKY),
            .SLOPE_SHIFT (SLOPE_SHIFT)
        ) u_lane (
            .i_fwd  (r_s1_fwd[32*i +: 32]),
            .i_grad (r_s1_grad[32*i +: 32]),
            .o_grad (w_lane_grad[32*i +: 32]),
            .o_neg  (w_neg[i])
        );
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            w_pop = w_pop + PC_W'(w_neg[i]);
        end
    end

    // Each stage advances when the one ahead of it is empty or draining.
    assign w_s2_ready = !r_s2_valid || out_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;
    assign w_out_hs   = r_s2_valid && out_ready;

    always_comb begin
        w_sum     = SUM_W'(r_count) + SUM_W'(r_s2_pop);
        w_count_d = r_count;
        if (clr_count) begin
            w_count_d = '0;
        end else if (w_out_hs) begin
            w_count_d = (w_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_fwd   <= '0;
            r_s1_grad  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_grad  <= '0;
            r_s2_pop   <= '0;
            r_count    <= '0;
        end else begin
            if (w_s1_ready) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_fwd  <= fwd_data;
                    r_s1_grad <= grad_in;
                end
            end
            if (w_s2_ready) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_grad <= w_lane_grad;
                    r_s2_pop  <= w_pop;
                end
            end
            r_count <= w_count_d;
        end
    end

    assign in_ready    = w_s1_ready;
    assign out_valid   = r_s2_valid;
    assign grad_out    = r_s2_grad;
    assign gated_count = r_count;

endmodule

// File: tb/tb_relu_backward_lanes.sv
// Randomised bench: three unit configurations share one stream and are checked against a beat queue model.
module tb_relu_backward_lanes;

    localparam int LANES = 4;
    localparam int W     = 32 * LANES;

    typedef struct {
        logic [W-1:0] f;
        logic [W-1:0] g;
        int           c;
    } beat_t;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] fwd_data;
    logic [W-1:0] grad_in;
    logic         out_ready;
    logic         clr_count;

    logic         in_ready_a, in_ready_b, in_ready_c;
    logic         out_valid_a, out_valid_b, out_valid_c;
    logic [W-1:0] grad_out_a, grad_out_b, grad_out_c;
    logic [31:0]  cnt_a, cnt_b;
    logic [3:0]   cnt_c;

    int      n_cmp = 0;
    int      n_bad = 0;
    int      cyc   = 0;
    beat_t   q[$];
    longint  m_cnt_a, m_cnt_b, m_cnt_c;

    relu_backward_lanes #(.LANES(LANES), .LEAKY(0), .SLOPE_SHIFT(3), .CNT_W(32)) u_dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .fwd_data(fwd_data), .grad_in(grad_in), .out_valid(out_valid_a),
        .out_ready(out_ready), .grad_out(grad_out_a), .clr_count(clr_count),
        .gated_count(cnt_a)
    );

    relu_backward_lanes #(.LANES(LANES), .LEAKY(1), .SLOPE_SHIFT(3), .CNT_W(32)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .fwd_data(fwd_data), .grad_in(grad_in), .out_valid(out_valid_b),
        .out_ready(out_ready), .grad_out(grad_out_b), .clr_count(clr_count),
        .gated_count(cnt_b)
    );

    relu_backward_lanes #(.LANES(LANES), .LEAKY(0), .SLOPE_SHIFT(3), .CNT_W(4)) u_dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_c),
        .fwd_data(fwd_data), .grad_in(grad_in), .out_valid(out_valid_c),
        .out_ready(out_ready), .grad_out(grad_out_c), .clr_count(clr_count),
        .gated_count(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, act, exp);
        end
    endtask

    // Positive means a non-zero value between the smallest +denormal and +Inf.
    function automatic bit lane_pos(logic [31:0] f);
        return (f >= 32'h1) && (f <= 32'h7F80_0000);
    endfunction

    function automatic logic [31:0] lane_ref(logic [31:0] f, logic [31:0] g, bit leaky);
        if (lane_pos(f)) return g;
        if (!leaky) return 32'h0;
        if (g[30:23] == 8'hFF) return g;
        if (g[30:23] <= 8'd3) return {g[31], 31'd0};
        return g - (32'd3 << 23);
    endfunction

    function automatic logic [W-1:0] beat_ref(logic [W-1:0] f, logic [W-1:0] g, bit leaky);
        logic [W-1:0] r;
        for (int i = 0; i < LANES; i++) r[32*i +: 32] = lane_ref(f[32*i +: 32], g[32*i +: 32], leaky);
        return r;
    endfunction

    function automatic int neg_count(logic [W-1:0] f);
        int n = 0;
        for (int i = 0; i < LANES; i++) if (!lane_pos(f[32*i +: 32])) n++;
        return n;
    endfunction

    function automatic longint sat_add(longint a, longint b, longint mx);
        return (a + b > mx) ? mx : a + b;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 7))
            0: w = 32'h0;
            1: w = 32'h8000_0000;
            2: w = {1'($urandom_range(0, 1)), 8'hFF, 1'b1, 22'($urandom)};
            3: w = {1'($urandom_range(0, 1)), 8'hFF, 23'd0};
            4: w = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 4)), 23'($urandom)};
            default: ;
        endcase
        return w;
    endfunction

    function automatic logic [W-1:0] rand_beat();
        logic [W-1:0] b;
        for (int i = 0; i < LANES; i++) b[32*i +: 32] = rand_word();
        return b;
    endfunction

    // One clock cycle: drive at negedge, check outputs and handshakes, then check counters.
    task automatic cycle(input logic v, input logic [W-1:0] f, input logic [W-1:0] g,
                         input logic ordy, input logic clr, output bit acc);
        bit    exp_ir, exp_ov;
        beat_t b;
        @(negedge clk);
        in_valid = v; fwd_data = f; grad_in = g; out_ready = ordy; clr_count = clr;
        #1;
        exp_ir = (q.size() < 2) || ordy;
        exp_ov = (q.size() > 0) && (q[0].c + 2 <= cyc);
        check("in_ready_a", W'(in_ready_a), W'(exp_ir));
        check("in_ready_b", W'(in_ready_b), W'(exp_ir));
        check("in_ready_c", W'(in_ready_c), W'(exp_ir));
        check("out_valid_a", W'(out_valid_a), W'(exp_ov));
        check("out_valid_b", W'(out_valid_b), W'(exp_ov));
        check("out_valid_c", W'(out_valid_c), W'(exp_ov));
        if (exp_ov) begin
            check("grad_out_a", grad_out_a, beat_ref(q[0].f, q[0].g, 1'b0));
            check("grad_out_b", grad_out_b, beat_ref(q[0].f, q[0].g, 1'b1));
            check("grad_out_c", grad_out_c, beat_ref(q[0].f, q[0].g, 1'b0));
        end
        if (clr) begin
            m_cnt_a = 0; m_cnt_b = 0; m_cnt_c = 0;
        end else if (exp_ov && ordy) begin
            m_cnt_a = sat_add(m_cnt_a, neg_count(q[0].f), 64'hFFFF_FFFF);
            m_cnt_b = sat_add(m_cnt_b, neg_count(q[0].f), 64'hFFFF_FFFF);
            m_cnt_c = sat_add(m_cnt_c, neg_count(q[0].f), 64'd15);
        end
        if (exp_ov && ordy) void'(q.pop_front());
        acc = v && exp_ir;
        if (acc) begin
            b.f = f; b.g = g; b.c = cyc;
            q.push_back(b);
        end
        cyc++;
        @(posedge clk);
        #1;
        check("gated_count_a", W'(cnt_a), W'(m_cnt_a));
        check("gated_count_b", W'(cnt_b), W'(m_cnt_b));
        check("gated_count_c", W'(cnt_c), W'(m_cnt_c));
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_out_valid_a"}, W'(out_valid_a), '0);
        check({tag, "_out_valid_b"}, W'(out_valid_b), '0);
        check({tag, "_out_valid_c"}, W'(out_valid_c), '0);
        check({tag, "_grad_out_a"}, grad_out_a, '0);
        check({tag, "_grad_out_b"}, grad_out_b, '0);
        check({tag, "_count_a"}, W'(cnt_a), '0);
        check({tag, "_count_b"}, W'(cnt_b), '0);
        check({tag, "_count_c"}, W'(cnt_c), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit           acc;
        logic         pend_v;
        logic [W-1:0] pend_f, pend_g;
        logic [W-1:0] bp_f[10];
        logic [W-1:0] bp_g[10];
        int           k;

        reset = 1'b0; in_valid = 1'b0; fwd_data = '0; grad_in = '0;
        out_ready = 1'b0; clr_count = 1'b0;
        m_cnt_a = 0; m_cnt_b = 0; m_cnt_c = 0;
        #12;
        check_reset("por");
        @(negedge clk);
        reset = 1'b1;

        // Sign classes, leaky scaling edge cases and a NaN activation.
        cycle(1'b1, {32'h8000_0000, 32'h0, 32'hBF80_0000, 32'h3F80_0000}, {4{32'h4000_0000}},
              1'b1, 1'b0, acc);
        cycle(1'b1, {4{32'hBF80_0000}}, {32'h7F80_0000, 32'hC000_0000, 32'h0080_0000, 32'h4000_0000},
              1'b1, 1'b0, acc);
        cycle(1'b1, {4{32'h7FC0_0000}}, {4{32'h3F80_0000}}, 1'b1, 1'b0, acc);
        idle(3);

        // Drive the 4-bit counter well past saturation.
        for (int i = 0; i < 5; i++) cycle(1'b1, {4{32'hBF80_0000}}, rand_beat(), 1'b1, 1'b0, acc);
        idle(3);

        // Clear lands on the same cycle as an output handshake.
        cycle(1'b1, {4{32'h8000_0000}}, rand_beat(), 1'b1, 1'b0, acc);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
        cycle(1'b0, '0, '0, 1'b1, 1'b1, acc);
        idle(2);

        // Backpressure: ten beats against a 1,0,0 ready pattern.
        for (int i = 0; i < 10; i++) begin
            bp_f[i] = rand_beat();
            bp_g[i] = rand_beat();
        end
        k = 0;
        for (int t = 0; t < 60; t++) begin
            if (k < 10) begin
                cycle(1'b1, bp_f[k], bp_g[k], (t % 3) == 0, 1'b0, acc);
                if (acc) k++;
            end else begin
                cycle(1'b0, '0, '0, (t % 3) == 0, 1'b0, acc);
            end
        end
        check("bp_beats_sent", W'(k), W'(10));
        check("bp_drained", W'(q.size()), '0);

        // Reset with two beats in flight.
        cycle(1'b1, rand_beat(), rand_beat(), 1'b0, 1'b0, acc);
        cycle(1'b1, rand_beat(), rand_beat(), 1'b0, 1'b0, acc);
        #2;
        reset = 1'b0;
        #1;
        check_reset("midrst");
        q.delete();
        m_cnt_a = 0; m_cnt_b = 0; m_cnt_c = 0;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, rand_beat(), rand_beat(), 1'b1, 1'b0, acc);
        idle(3);

        // Random traffic; an unaccepted beat is held until taken.
        pend_v = 1'b0; pend_f = '0; pend_g = '0;
        for (int t = 0; t < 600; t++) begin
            if (!pend_v && ($urandom_range(0, 3) != 0)) begin
                pend_v = 1'b1;
                pend_f = rand_beat();
                pend_g = rand_beat();
            end
            cycle(pend_v, pend_f, pend_g, $urandom_range(0, 4) > 1,
                  $urandom_range(0, 40) == 0, acc);
            if (acc) pend_v = 1'b0;
        end

        for (int t = 0; t < 20 && q.size() > 0; t++) idle(1);
        check("final_drain", W'(q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
